// File: rtl/tap_streamer.sv
// ============================================================================
// tap_streamer: 3-tap FIR product streamer. It emits h0*w0, h1*w1 and h2*w2,
// one product per cycle, to a downstream accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tap_streamer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        coef_wr,
  input  logic [1:0]  coef_idx,
  input  logic [15:0] coef_data,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_first,
  output logic        m_last,
  output logic [15:0] group_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAP0 = 2'd1,
    TAP1 = 2'd2,
    TAP2 = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] h0, h1, h2;
  logic [15:0] w0, w1, w2;
  logic [1:0]  fill;
  logic        accept;
  logic [15:0] tap_coef;
  logic [15:0] tap_samp;

  // Gating with reset keeps s_ready low for the whole time reset is held.
  assign s_ready = reset && (state == IDLE) && !clear;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (fill >= 2'd2)) state_next = TAP0;
      TAP0:    state_next = TAP1;
      TAP1:    state_next = TAP2;
      TAP2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_comb begin
    m_valid  = 1'b0;
    m_first  = 1'b0;
    m_last   = 1'b0;
    tap_coef = 16'd0;
    tap_samp = 16'd0;
    case (state)
      TAP0: begin
        m_valid  = 1'b1;
        m_first  = 1'b1;
        tap_coef = h0;
        tap_samp = w0;
      end
      TAP1: begin
        m_valid  = 1'b1;
        tap_coef = h1;
        tap_samp = w1;
      end
      TAP2: begin
        m_valid  = 1'b1;
        m_last   = 1'b1;
        tap_coef = h2;
        tap_samp = w2;
      end
      default: ;
    endcase
    // Operands are zero in IDLE, so m_data is 0 there without a separate mux.
    m_data = $signed({{16{tap_coef[15]}}, tap_coef}) *
             $signed({{16{tap_samp[15]}}, tap_samp});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fill      <= 2'd0;
      w0        <= 16'd0;
      w1        <= 16'd0;
      w2        <= 16'd0;
      h0        <= 16'd0;
      h1        <= 16'd0;
      h2        <= 16'd0;
      group_cnt <= 16'd0;
    end else begin
      state <= state_next;

      if (clear) begin
        fill <= 2'd0;
        w0   <= 16'd0;
        w1   <= 16'd0;
        w2   <= 16'd0;
      end else if (accept) begin
        w2 <= w1;
        w1 <= w0;
        w0 <= s_data;
        if (fill != 2'd3) fill <= fill + 2'd1;
      end

      if (coef_wr && (state == IDLE)) begin
        case (coef_idx)
          2'd0:    h0 <= coef_data;
          2'd1:    h1 <= coef_data;
          2'd2:    h2 <= coef_data;
          default: ;
        endcase
      end

      // A clear during TAP2 abandons that group, so it is not counted.
      if ((state == TAP2) && !clear) group_cnt <= group_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tap_streamer.sv
// Scoreboard bench for tap_streamer: a sample-history model predicts each
// group's products and the s_ready / group_cnt behaviour cycle by cycle.
`default_nettype none

module tb_tap_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        coef_wr;
  logic [1:0]  coef_idx;
  logic [15:0] coef_data;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_first;
  logic        m_last;
  logic [15:0] group_cnt;

  tap_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .coef_wr   (coef_wr),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_first   (m_first),
    .m_last    (m_last),
    .group_cnt (group_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        f;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Reference state: coefficients, recent-sample history (newest first),
  // cycles of product output still owed, and completed-group count.
  int          h_m[3];
  int          hist[$];
  int          busy = 0;
  logic [15:0] gcnt = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    h_m = '{0, 0, 0};
    hist.delete();
    busy = 0;
    gcnt = 16'd0;
    sb.delete();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic clr, input logic wr, input logic [1:0] idx,
                       input logic [15:0] cd, input logic sv, input logic [15:0] sd);
    logic rdy;
    clear = clr; coef_wr = wr; coef_idx = idx; coef_data = cd;
    s_valid = sv; s_data = sd;
    rdy = (busy == 0) && !clr;
    #1;
    chk("s_ready", 64'(s_ready), 64'(rdy));
    chk("group_cnt", 64'(group_cnt), 64'(gcnt));
    @(posedge clk);
    if (wr && busy == 0 && idx != 2'd3) h_m[idx] = int'($signed(cd));
    if (clr) begin
      hist.delete();
      busy = 0;
      sb.delete();
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) gcnt++;
    end else if (sv && rdy) begin
      hist.push_front(int'($signed(sd)));
      if (hist.size() > 3) void'(hist.pop_back());
      if (hist.size() == 3) begin
        busy = 3;
        for (int k = 0; k < 3; k++) begin
          exp_t e;
          e.d = 32'(h_m[k] * hist[k]);
          e.f = (k == 0);
          e.l = (k == 2);
          sb.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 16'd0);
  endtask

  task automatic wcoef(input logic [1:0] idx, input logic [15:0] v);
    cycle(1'b0, 1'b1, idx, v, 1'b0, 16'd0);
  endtask

  task automatic samp(input logic [15:0] v);
    cycle(1'b0, 1'b0, 2'd0, 16'd0, 1'b1, v);
  endtask

  // Monitor: every cycle, either a product matching the scoreboard head or all-zero outputs.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_m_valid: got m_data %0h with empty scoreboard at %0t", m_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("m_data", 64'(m_data), 64'(e.d));
        chk("m_first_last", 64'({m_first, m_last}), 64'({e.f, e.l}));
      end
    end else begin
      chk("idle_outputs", 64'({m_data, m_first, m_last}), 64'd0);
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; coef_wr = 1'b0; coef_idx = 2'd0;
    coef_data = 16'd0; s_valid = 1'b0; s_data = 16'd0;
    model_reset();
    #1;
    chk("reset_outputs", 64'({m_data, m_valid, m_first, m_last, s_ready, group_cnt}), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Basic streaming and a continuing stream.
    wcoef(2'd0, 16'd1); wcoef(2'd1, 16'd2); wcoef(2'd2, 16'd3);
    samp(16'd10); idle(1); samp(16'd20); idle(1); samp(16'd30);
    idle(4);
    chk("group_cnt_after_first", 64'(group_cnt), 64'd1);
    samp(16'd40);
    idle(4);
    chk("group_cnt_after_second", 64'(group_cnt), 64'd2);

    // Signed extremes.
    wcoef(2'd0, 16'h8000); wcoef(2'd1, 16'h7FFF); wcoef(2'd2, 16'hFFFF);
    samp(16'd5); samp(16'h8000); samp(16'h8000);
    idle(4);

    // Clear during TAP1, then three fresh samples are needed.
    samp(16'd7); idle(1);
    cycle(1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 16'd9);
    idle(2);
    chk("group_cnt_after_clear", 64'(group_cnt), 64'd3);
    samp(16'd1); samp(16'd2); idle(3); samp(16'd3); idle(4);

    // Coefficient write during TAP0 is ignored; same-edge write with sample is used.
    wcoef(2'd0, 16'd4);
    samp(16'd11);
    cycle(1'b0, 1'b1, 2'd0, 16'd99, 1'b0, 16'd0);
    idle(3);
    cycle(1'b0, 1'b1, 2'd1, 16'd5, 1'b1, 16'd12);
    idle(3);
    wcoef(2'd3, 16'd77);
    samp(16'd13); idle(4);

    // Reset asserted during TAP1.
    samp(16'd21); idle(1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", 64'({m_data, m_valid, m_first, m_last, s_ready, group_cnt}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    samp(16'd1); samp(16'd2); idle(3);
    wcoef(2'd0, 16'd3); wcoef(2'd1, 16'hFFFE); wcoef(2'd2, 16'd6);
    samp(16'd3); idle(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 1) == 1),
            16'($urandom));
    end
    idle(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tap_streamer.md
TAP_STREAMER -- requirements
Module: tap_streamer

Interface
REQ-001 SHALL have clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have clear, input, 1 bit: synchronous flush of the window and any group in progress.
REQ-004 SHALL have coef_wr, input, 1 bit: coefficient write strobe.
REQ-005 SHALL have coef_idx, input, 2 bits: coefficient index; 0..2 valid, 3 ignored.
REQ-006 SHALL have coef_data, input, 16 bits: signed coefficient value.
REQ-007 SHALL have s_data, input, 16 bits: signed input sample.
REQ-008 SHALL have s_valid, input, 1 bit: sample offered.
REQ-009 SHALL have s_ready, output, 1 bit: sample accepted on an edge where s_valid and s_ready are both 1.
REQ-010 SHALL have m_data, output, 32 bits: signed tap product to the downstream accumulator.
REQ-011 SHALL have m_valid, output, 1 bit: m_data valid this cycle; no backpressure.
REQ-012 SHALL have m_first, output, 1 bit: first product of a group (tap 0); drives the accumulator's group-start input.
REQ-013 SHALL have m_last, output, 1 bit: last product of a group (tap 2).
REQ-014 SHALL have group_cnt, output, 16 bits: number of completed groups, wrapping.

Function
REQ-015 SHALL hold coefficients h0..h2, each 16-bit signed.
REQ-016 SHALL hold a sample window w0..w2, where w0 is newest; an accepted sample shifts the window (w2<=w1, w1<=w0, w0<=s_data).
REQ-017 SHALL keep a fill counter that saturates at 3 and increments on each accepted sample.
REQ-018 SHALL implement states IDLE, TAP0, TAP1, TAP2.
- Reset state is IDLE.
- IDLE -> TAP0 on an accepted sample that leaves fill at 3; otherwise IDLE holds.
- TAP0 -> TAP1 -> TAP2 -> IDLE, unconditionally, one cycle each.
REQ-019 SHALL drive s_ready = (state==IDLE) and not clear; no sample is accepted in TAP states.
REQ-020 SHALL, in state TAPk, drive m_valid=1 and m_data = hk * w(k), a full-precision signed 32-bit product (y[n] = h0·x[n] + h1·x[n-1] + h2·x[n-2]).
- m_first=1 only in TAP0; m_last=1 only in TAP2.
- In IDLE, m_valid, m_first and m_last are 0 and m_data is 0.
REQ-021 SHALL drive m_* from state, window and coefficient registers only, with no combinational path from s_* or coef_* to m_*.
REQ-022 SHALL have a latency such that a sample accepted at edge T gives m_valid high in the three cycles after T, and s_ready high again in the fourth cycle; maximum throughput is one group per 4 cycles.
REQ-023 SHALL increment group_cnt on the TAP2 -> IDLE edge, wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL write coef_data to h[coef_idx] when coef_wr=1 and state==IDLE.
- Writes in TAP states are ignored.
- Writes with coef_idx=3 are ignored.
REQ-025 SHALL, on clear=1, set next state to IDLE, fill to 0 and the window to 0.
- Any group in progress is abandoned; m_valid is 0 from the next cycle.
- group_cnt and coefficients are unchanged.
- Clear wins over a simultaneous s_valid; that sample is not accepted.
REQ-026 SHALL make a coefficient write in the same cycle as an accepted sample take effect for the group that sample triggers.

Reset
REQ-027 SHALL, while reset=0, force state=IDLE; fill=0; w0..w2=0; h0..h2=0; group_cnt=0; m_data=0; m_valid=m_first=m_last=0; s_ready=0.
REQ-028 SHALL drive s_ready=1 in the first cycle after reset deasserts, provided clear=0.
REQ-029 SHALL, on reset assertion mid-group, drop m_valid to 0 immediately; no partial-group completion after release.

Verification
REQ-030 SHALL cover basic streaming.
- Stimulus: h=(1,2,3), samples 10,20,30.
- Response: no m_valid for the first two samples; after 30, m_data=30,40,30 with first/last on taps 0/2; group_cnt=1.
REQ-031 SHALL cover a continuing stream.
- Stimulus: after REQ-030, sample 40.
- Response: m_data=40,60,60; s_ready low exactly 3 cycles; group_cnt=2.
REQ-032 SHALL cover signed extremes.
- Stimulus: h0=-32768, h1=32767, h2=-1, samples 5,-32768,-32768.
- Response: m_data=0x40000000, 0xC0008000, 0xFFFFFFFB.
REQ-033 SHALL cover clear mid-group.
- Stimulus: clear=1 in the TAP1 cycle.
- Response: m_valid=0 next cycle; group_cnt unchanged; 3 new samples needed before the next group.
REQ-034 SHALL cover a coefficient write while busy.
- Stimulus: coef_wr with idx 0, value 99 during TAP0.
- Response: h0 unchanged; the next group uses the old h0.
REQ-035 SHALL cover reset mid-operation.
- Stimulus: reset=0 during TAP1.
- Response: all outputs 0 asynchronously; after release, s_ready=1 and fill=0.
